// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding,
// register offsets and vector width.
package irq_pkg;

  localparam int VEC_W       = 3;
  localparam int STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUEST    = 2'd1,
    IN_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req and
// whether any bit is set at all.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic [VEC_W-1:0] id,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = VEC_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge capture into a pending register, CPU mask,
// fixed-priority selection and a req/ack/eoi handshake toward the cpu.
// Handshake: irq_req is held while a request is offered and irq_vec names
// it; the cpu answers with a one-cycle irq_ack pulse (taken on that edge),
// and later a one-cycle irq_eoi pulse ends the handler.
// Optional nesting of higher-priority sources is enabled by defining
// IRQ_NESTED_EN.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          N_SRC     = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  input  logic [15:0]      bus_addr,
  input  logic [15:0]      bus_wdata,
  input  logic             bus_we,
  output logic [15:0]      bus_rdata,
  output logic             bus_hit
);

  irq_state_e       state, state_next;
  logic [N_SRC-1:0] mask, pending, src_prev;
  logic [N_SRC-1:0] rising, eligible, clr_bus, clr_ack, pend_next;
  logic [VEC_W-1:0] winner, active, pop_id;
  logic             any;
  logic             take, push, pop, nest_ok;
  logic [2:0]       depth;
  logic [15:0]      offset;
  logic [1:0]       sel;
  logic             wr_mask, wr_pend;
  logic             unused_bits;

  // Address decode; 17-bit compare so a base near the top of memory
  // does not wrap.
  assign offset  = bus_addr - BASE_ADDR;
  assign sel     = offset[1:0];
  assign bus_hit = ({1'b0, bus_addr} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, bus_addr} <= ({1'b0, BASE_ADDR} + 17'd2));
  assign wr_mask = bus_we && bus_hit && (sel == REG_MASK);
  assign wr_pend = bus_we && bus_hit && (sel == REG_PEND);
  assign unused_bits = ^{offset[15:2], bus_wdata[15:N_SRC]};

  assign rising   = irq_src & ~src_prev;
  assign eligible = pending & mask;

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .req   (eligible),
    .id    (winner),
    .valid (any)
  );

`ifdef IRQ_NESTED_EN
  logic [VEC_W-1:0] stack [STACK_DEPTH];

  assign nest_ok = any && (winner < active) && (depth < 3'(STACK_DEPTH));
  assign pop_id  = stack[2'(depth - 3'd1)];

  // Saved-id stack: push the interrupted id on a nested ack, pop on eoi.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth <= 3'd0;
    end else if (push) begin
      stack[depth[1:0]] <= active;
      depth             <= depth + 3'd1;
    end else if (pop) begin
      depth <= depth - 3'd1;
    end
  end
`else
  assign nest_ok = 1'b0;
  assign pop_id  = '0;
  assign depth   = 3'd0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state;
    irq_req    = 1'b0;
    irq_vec    = '0;
    take       = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (any) state_next = REQUEST;
      end
      REQUEST: begin
        irq_req = any;
        irq_vec = winner;
        if (!any) begin
          state_next = IDLE;
        end else if (irq_ack) begin
          take       = 1'b1;
          state_next = IN_SERVICE;
        end
      end
      IN_SERVICE: begin
        irq_req = nest_ok;
        irq_vec = nest_ok ? winner : active;
        if (nest_ok && irq_ack) begin
          take = 1'b1;
          push = 1'b1;
        end else if (irq_eoi) begin
          if (depth != 3'd0) pop = 1'b1;
          else               state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending update: W1C and ack clears first, then new edges win.
  always_comb begin
    clr_bus = wr_pend ? bus_wdata[N_SRC-1:0] : '0;
    clr_ack = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr_ack[i] = take && (winner == VEC_W'(i));
    end
    pend_next = (pending & ~clr_bus & ~clr_ack) | rising;
  end

  // Mask, pending, edge history and active id registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask     <= '0;
      pending  <= '0;
      src_prev <= '0;
      active   <= '0;
    end else begin
      src_prev <= irq_src;
      pending  <= pend_next;
      if (wr_mask) mask <= bus_wdata[N_SRC-1:0];
      if (take)     active <= winner;
      else if (pop) active <= pop_id;
    end
  end

  // Combinational register read-back.
  always_comb begin
    bus_rdata = 16'h0000;
    if (bus_hit) begin
      case (sel)
        REG_MASK: bus_rdata[N_SRC-1:0] = mask;
        REG_PEND: bus_rdata[N_SRC-1:0] = pending;
        REG_STAT: begin
          bus_rdata[15]  = (state == IN_SERVICE);
          bus_rdata[6:4] = depth;
          bus_rdata[2:0] = active;
        end
        default: bus_rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios followed by random traffic,
// every cycle checked against a behavioural model through an expected queue.
module tb_irq_controller;

  localparam int BASE = 'hFF00;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic        irq_req;
  logic [2:0]  irq_vec;
  logic        irq_ack, irq_eoi;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_hit;

  // Clock.
  always #5 clk = ~clk;

  irq_controller dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .irq_req   (irq_req),
    .irq_vec   (irq_vec),
    .irq_ack   (irq_ack),
    .irq_eoi   (irq_eoi),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .bus_hit   (bus_hit)
  );

  // Reference model: what the cpu should observe.
  logic [7:0] m_mask, m_pend, m_prev;
  bit         m_busy;       // a source offered or in service
  bit         m_serving;    // handler running
  int         m_active;

  logic [20:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Advance the model over one clock edge using the inputs present at it.
  task automatic model_step();
    int w;
    logic [7:0] np;
    if (reset) begin
      m_mask = 0; m_pend = 0; m_prev = 0;
      m_busy = 0; m_serving = 0; m_active = 0;
      return;
    end
    w  = lowest(m_pend & m_mask);
    np = m_pend;
    if (bus_we && int'(bus_addr) == BASE + 1) np = np & ~bus_wdata[7:0];
    if (m_serving) begin
      if (irq_eoi) begin m_serving = 0; m_busy = 0; end
    end else if (m_busy) begin
      if (w < 0) m_busy = 0;
      else if (irq_ack) begin
        m_active  = w;
        np[w]     = 1'b0;
        m_serving = 1;
      end
    end else if (w >= 0) begin
      m_busy = 1;
    end
    np     = np | (irq_src & ~m_prev);
    m_pend = np;
    m_prev = irq_src;
    if (bus_we && int'(bus_addr) == BASE) m_mask = bus_wdata[7:0];
  endtask

  function automatic logic [20:0] model_out();
    int w, a;
    logic req, hit;
    logic [2:0] vec;
    logic [15:0] rd;
    w   = lowest(m_pend & m_mask);
    req = m_busy && !m_serving && (w >= 0);
    vec = 3'd0;
    if (m_serving) vec = 3'(m_active);
    else if (req)  vec = 3'(w);
    a   = int'(bus_addr);
    hit = (a >= BASE) && (a <= BASE + 2);
    rd  = 16'h0000;
    if (a == BASE)          rd = {8'h00, m_mask};
    else if (a == BASE + 1) rd = {8'h00, m_pend};
    else if (a == BASE + 2) begin
      rd[15]  = m_serving;
      rd[2:0] = 3'(m_active);
    end
    return {req, vec, hit, rd};
  endfunction

  // Driver: one clock per call; expectation for the new inputs is queued.
  task automatic cycle(input logic rst, input logic [7:0] src, input logic ack,
                       input logic eoi, input logic we, input int addr,
                       input logic [15:0] wdata);
    @(posedge clk);
    #1;
    model_step();
    reset     = rst;
    irq_src   = src;
    irq_ack   = ack;
    irq_eoi   = eoi;
    bus_we    = we;
    bus_addr  = 16'(addr);
    bus_wdata = wdata;
    exp_q.push_back(model_out());
  endtask

  logic [7:0] src_hold;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, src_hold, 1'b0, 1'b0, 1'b0, BASE + (i % 3), 16'h0);
  endtask

  task automatic wr(input int off, input logic [15:0] d);
    cycle(1'b0, src_hold, 1'b0, 1'b0, 1'b1, BASE + off, d);
  endtask

  task automatic ack();
    cycle(1'b0, src_hold, 1'b1, 1'b0, 1'b0, BASE + 2, 16'h0);
  endtask

  task automatic eoi();
    cycle(1'b0, src_hold, 1'b0, 1'b1, 1'b0, BASE + 1, 16'h0);
  endtask

  // Scoreboard monitor: compare the DUT against the oldest expectation.
  always @(negedge clk) begin
    logic [20:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {irq_req, irq_vec, bus_hit, bus_rdata};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL cycle t=%0t got req=%b vec=%0d hit=%b rdata=%h want req=%b vec=%0d hit=%b rdata=%h",
                 $time, g[20], g[19:17], g[16], g[15:0], e[20], e[19:17], e[16], e[15:0]);
      end
    end
  end

  initial begin
    int addr;
    logic [15:0] d;
    logic [7:0] flip;
    reset = 1'b1; irq_src = 0; irq_ack = 0; irq_eoi = 0;
    bus_we = 0; bus_addr = 16'(BASE + 2); bus_wdata = 0;
    m_mask = 0; m_pend = 0; m_prev = 0; m_busy = 0; m_serving = 0; m_active = 0;
    src_hold = 8'h00;

    cycle(1'b1, 8'h00, 0, 0, 0, BASE + 2, 16'h0);
    cycle(1'b1, 8'h00, 0, 0, 0, BASE, 16'h0);
    // Basic capture and request latency on source 3.
    src_hold = 0; wr(0, 16'h00FF); idle(3);
    src_hold = 8'h08; idle(1); src_hold = 8'h00; idle(3);
    ack(); idle(2); eoi(); idle(2);
    // Two simultaneous edges: 2 first, then 5.
    src_hold = 8'h24; idle(3); ack(); idle(2); eoi(); idle(3); ack(); idle(1); eoi();
    src_hold = 8'h00; idle(2);
    // Masked source becomes eligible, then is masked away before ack.
    wr(0, 16'h0000); src_hold = 8'h40; idle(3);
    wr(0, 16'h0040); idle(3); wr(0, 16'h0000); idle(3);
    wr(1, 16'h0040); src_hold = 8'h00; idle(1);
    // Bit 0 arriving while 4 is in service waits for eoi.
    wr(0, 16'h00FF); src_hold = 8'h10; idle(3); ack();
    src_hold = 8'h11; idle(3); eoi(); idle(2); ack(); idle(1); eoi();
    src_hold = 8'h00; idle(2);
    // Spurious handshakes and W1C racing a new edge.
    ack(); idle(1); src_hold = 8'h02; idle(2); eoi(); idle(1);
    src_hold = 8'h03; wr(1, 16'h0001); idle(2); wr(1, 16'h0003); idle(2);
    // Reset while in service.
    src_hold = 8'h00; idle(1); src_hold = 8'h80; idle(3); ack(); idle(1);
    cycle(1'b1, src_hold, 0, 0, 0, BASE, 16'h0);
    idle(3); src_hold = 8'h00; idle(1);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      flip = 8'h00;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) flip[b] = 1'b1;
      src_hold = src_hold ^ flip;
      case ($urandom_range(0, 9))
        0:       addr = int'(16'($urandom));
        1:       addr = BASE - 1;
        default: addr = BASE + $urandom_range(0, 3);
      endcase
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 0) d[7:0] = d[7:0] | 8'($urandom);
      cycle(($urandom_range(0, 299) == 0), src_hold,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), addr, d);
    end

    cycle(1'b0, 8'h00, 0, 0, 0, BASE, 16'h0);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
